ahb_rr_arbiter: RTL and testbench

- Bus arbiter for the multi-master AHB interconnect; shares the bus between MASTER_NUM masters using round-robin priority.
- Burst-aware: it holds the grant for the whole of a fixed-length burst and for a bounded INCR burst.
- Drives HGRANT one-hot and the HMASTER index, which selects the master-to-slave address/data mux.
- Parks on a default master when no master requests the bus.

---
 rtl/integration_pkg.sv | 51 +++++
 rtl/rr_pick.sv | 28 ++
 rtl/ahb_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/integration_pkg.sv
// Shared AHB interconnect types, master count and arbiter state encoding.
package integration_pkg;

  localparam int master_number = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } transfer_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ARB,
    BURST,
    INCR_HOLD,
    LOCKED
  } arb_state_t;

  // Beats in a burst; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_beats(burst_t b);
    burst_beats = 5'd1;
    case (b)
      SINGLE:        burst_beats = 5'd1;
      INCR:          burst_beats = 5'd0;
      WRAP4, INCR4:  burst_beats = 5'd4;
      WRAP8, INCR8:  burst_beats = 5'd8;
      WRAP16, INCR16: burst_beats = 5'd16;
      default:       burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester after ptr, cyclically; ptr itself last.
module rr_pick #(
  parameter int N = 9,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  localparam int unsigned NU = N;

  // Scan farthest-first so the nearest request after ptr is the last write.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    base   = 32'(ptr);
    idx    = 0;
    winner = '0;
    valid  = |req;
    for (int unsigned k = NU; k >= 1; k--) begin
      idx = (base + k) % NU;
      if (req[W'(idx)]) winner = W'(idx);
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Burst-aware round-robin AHB arbiter with default-master parking.
// Optional locked transfers: define AHB_ARB_LOCK_EN to add HLOCK/HMASTLOCK.
module ahb_rr_arbiter
  import integration_pkg::*;
#(
  parameter  int MASTER_NUM     = master_number,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int MAX_INCR_BEATS = 16,
  localparam int MW             = $clog2(MASTER_NUM)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [MASTER_NUM-1:0] HBUSREQ,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  output logic [MASTER_NUM-1:0] HGRANT,
  output logic [MW-1:0]         HMASTER
`ifdef AHB_ARB_LOCK_EN
  ,
  input  logic [MASTER_NUM-1:0] HLOCK,
  output logic                  HMASTLOCK
`endif
);

  localparam int IW = $clog2(MAX_INCR_BEATS + 1);
  localparam logic [MW-1:0]         DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] DEF_GRANT = MASTER_NUM'(1) << DEFAULT_MASTER;

  arb_state_t            state;
  logic [MW-1:0]         owner;
  logic [MW-1:0]         rr_ptr;
  logic [3:0]            beat_cnt;
  logic [IW-1:0]         incr_cnt;

  transfer_t             trans;
  burst_t                burst;
  resp_t                 resp;
  logic [4:0]            beats;
  logic                  early_term;
  logic                  retry_term;
  logic [MW-1:0]         pick_ptr;
  logic [MW-1:0]         pick_idx;
  logic                  pick_valid;
  logic [MW-1:0]         win_idx;
  logic [MASTER_NUM-1:0] win_grant;
  logic [IW-1:0]         next_incr;
  logic                  incr_exit;
  logic                  lock_start;
  logic                  lock_release;
  logic                  rearb;

  rr_pick #(
    .N(MASTER_NUM),
    .W(MW)
  ) u_pick (
    .req   (HBUSREQ),
    .ptr   (pick_ptr),
    .winner(pick_idx),
    .valid (pick_valid)
  );

  // Decode bus inputs and form the candidate grant for this edge.
  always_comb begin
    trans      = transfer_t'(HTRANS);
    burst      = burst_t'(HBURST);
    resp       = resp_t'(HRESP);
    beats      = burst_beats(burst);
    early_term = (resp != OKAY);
    retry_term = (resp == RETRY) || (resp == SPLIT);
    // A retried/split owner is scanned from itself so it lands last.
    pick_ptr   = retry_term ? owner : rr_ptr;
    win_idx    = pick_valid ? pick_idx : DEF_IDX;
    win_grant  = '0;
    win_grant[win_idx] = 1'b1;
    next_incr  = incr_cnt + IW'(trans == SEQ);
    incr_exit  = !HBUSREQ[owner] || (trans == IDLE) ||
                 (next_incr >= IW'(MAX_INCR_BEATS));
`ifdef AHB_ARB_LOCK_EN
    lock_start   = (trans == NONSEQ) && HLOCK[owner];
    lock_release = !HLOCK[owner] && ((trans == IDLE) || (trans == NONSEQ));
`else
    lock_start   = 1'b0;
    lock_release = 1'b1;
`endif
  end

  // Decide whether this HREADY-high edge hands the grant out again.
  always_comb begin
    rearb = 1'b0;
    if (early_term) begin
      rearb = 1'b1;
    end else begin
      case (state)
        ARB:       rearb = !(lock_start || ((trans == NONSEQ) && (beats != 5'd1)));
        BURST:     rearb = (trans == SEQ) && (beat_cnt == 4'd1);
        INCR_HOLD: rearb = incr_exit;
        LOCKED:    rearb = lock_release;
        default:   rearb = 1'b1;
      endcase
    end
  end

  // Grant, ownership, round-robin pointer and burst tracking.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT   <= DEF_GRANT;
      HMASTER  <= DEF_IDX;
      owner    <= DEF_IDX;
      rr_ptr   <= DEF_IDX;
      state    <= ARB;
      beat_cnt <= '0;
      incr_cnt <= '0;
    end else if (HREADY) begin
      HMASTER <= owner;
      if (rearb) begin
        HGRANT <= win_grant;
        owner  <= win_idx;
        if (win_idx != owner) rr_ptr <= win_idx;
        else if (retry_term)  rr_ptr <= owner;
      end
      if (early_term) begin
        state    <= ARB;
        beat_cnt <= '0;
        incr_cnt <= '0;
      end else begin
        case (state)
          ARB: begin
            if (lock_start) begin
              state <= LOCKED;
            end else if ((trans == NONSEQ) && (beats == 5'd0)) begin
              state    <= INCR_HOLD;
              incr_cnt <= IW'(1);
            end else if ((trans == NONSEQ) && (beats > 5'd1)) begin
              state    <= BURST;
              beat_cnt <= 4'(beats - 5'd1);
            end
          end
          BURST: begin
            if (trans == SEQ) begin
              if (beat_cnt == 4'd1) begin
                state    <= ARB;
                beat_cnt <= '0;
              end else begin
                beat_cnt <= beat_cnt - 4'd1;
              end
            end
          end
          INCR_HOLD: begin
            if (incr_exit) begin
              state    <= ARB;
              incr_cnt <= '0;
            end else begin
              incr_cnt <= next_incr;
            end
          end
          LOCKED: begin
            if (lock_release) state <= ARB;
          end
          default: state <= ARB;
        endcase
      end
    end
  end

`ifdef AHB_ARB_LOCK_EN
  // Lock indication follows the owner into the address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    HMASTLOCK <= 1'b0;
    else if (HREADY) HMASTLOCK <= HLOCK[owner];
  end
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed vectors, literal pins and a cycle model.
module tb_ahb_rr_arbiter;

  localparam int N    = 9;
  localparam int DEFM = 0;
  localparam int MAXI = 16;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                         B_INCR8 = 3'd5, B_INCR16 = 3'd7;
  localparam logic [1:0] R_OKAY = 2'd0, R_RETRY = 2'd2;

  localparam int M_FREE = 0, M_FIXED = 1, M_INCR = 2;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [8:0] HBUSREQ = '0;
  logic [1:0] HTRANS = T_IDLE;
  logic [2:0] HBURST = B_SINGLE;
  logic       HREADY = 1'b1;
  logic [1:0] HRESP = R_OKAY;
  logic [8:0] HGRANT;
  logic [3:0] HMASTER;

  int checks = 0;
  int passed = 0;

  int m_owner, m_hmaster, m_ptr, m_mode, m_done, m_total, m_taken;

  ahb_rr_arbiter #(
    .MASTER_NUM(N),
    .DEFAULT_MASTER(DEFM),
    .MAX_INCR_BEATS(MAXI)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .HBUSREQ(HBUSREQ),
    .HTRANS (HTRANS),
    .HBURST (HBURST),
    .HREADY (HREADY),
    .HRESP  (HRESP),
    .HGRANT (HGRANT),
    .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_pick(input int from, input logic [8:0] req);
    for (int s = 1; s <= N; s++) begin
      int c;
      c = (from + s) % N;
      if (req[c]) return c;
    end
    return DEFM;
  endfunction

  // Reference model: who owns the bus after each accepted edge.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_owner = DEFM; m_hmaster = DEFM; m_ptr = DEFM;
      m_mode = M_FREE; m_done = 0; m_total = 0; m_taken = 0;
    end else if (HREADY) begin
      bit arb;
      int base;
      int total;
      int w;
      arb  = 1'b0;
      base = m_ptr;
      m_hmaster = m_owner;
      if (HRESP != R_OKAY) begin
        arb = 1'b1;
        m_mode = M_FREE;
        if (HRESP >= R_RETRY) base = m_owner;
      end else if (m_mode == M_FREE) begin
        if (HTRANS == T_NONSEQ) begin
          if (HBURST == B_SINGLE) total = 1;
          else if (HBURST == B_INCR) total = 0;
          else total = 4 << ((int'(HBURST) - 2) / 2);
          if (total == 0) begin m_mode = M_INCR; m_taken = 1; end
          else if (total > 1) begin m_mode = M_FIXED; m_done = 1; m_total = total; end
          else arb = 1'b1;
        end else arb = 1'b1;
      end else if (m_mode == M_FIXED) begin
        if (HTRANS == T_SEQ) begin
          m_done++;
          if (m_done == m_total) begin arb = 1'b1; m_mode = M_FREE; end
        end
      end else begin
        if (!HBUSREQ[m_owner] || HTRANS == T_IDLE) begin
          arb = 1'b1; m_mode = M_FREE;
        end else if (HTRANS == T_SEQ) begin
          m_taken++;
          if (m_taken >= MAXI) begin arb = 1'b1; m_mode = M_FREE; end
        end
      end
      if (arb) begin
        w = m_pick(base, HBUSREQ);
        if (w != m_owner) m_ptr = w;
        else if (HRESP >= R_RETRY) m_ptr = m_owner;
        m_owner = w;
      end
    end
  end

  // Every mid-cycle point: outputs must agree with the model.
  always @(negedge HCLK) begin
    chk("model_grant", 32'(HGRANT), 32'd1 << m_owner);
    chk("model_hmaster", 32'(HMASTER), 32'(m_hmaster));
  end

  task automatic cyc(input logic [8:0] req, input logic [1:0] tr, input logic [2:0] bu,
                     input logic rdy, input logic [1:0] rsp);
    HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  initial begin
    logic [1:0] seq8 [9];
    logic [8:0] hold_req [5];
    seq8     = '{T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
    hold_req = '{9'h001, 9'h0FF, 9'h010, 9'h1FF, 9'h000};

    // Reset and parking
    repeat (2) @(negedge HCLK);
    chk("rst_grant", 32'(HGRANT), 32'h001);
    chk("rst_hmaster", 32'(HMASTER), 32'd0);
    HRESETn = 1'b1;
    repeat (10) cyc(9'h000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    chk("park_grant", 32'(HGRANT), 32'h001);
    chk("park_hmaster", 32'(HMASTER), 32'd0);

    // Round robin over masters 5, 7, 8 with single transfers
    cyc(9'h1A0, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rr_m5", 32'(HGRANT), 32'h020);
    cyc(9'h1A0, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rr_m7", 32'(HGRANT), 32'h080);
    chk("rr_hm5", 32'(HMASTER), 32'd5);
    cyc(9'h1A0, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rr_m8", 32'(HGRANT), 32'h100);
    cyc(9'h1A0, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rr_m5b", 32'(HGRANT), 32'h020);
    repeat (2) cyc(9'h000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    chk("park2", 32'(HGRANT), 32'h001);

    // Master 3 INCR8 with two BUSY beats; master 6 waits, 3 drops its request mid-burst
    cyc(9'h048, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("b8_grant3", 32'(HGRANT), 32'h008);
    cyc(9'h048, T_NONSEQ, B_INCR8, 1'b1, R_OKAY); chk("b8_beat1", 32'(HGRANT), 32'h008);
    for (int i = 0; i < 9; i++) begin
      cyc((i < 2) ? 9'h048 : 9'h040, seq8[i], B_INCR8, 1'b1, R_OKAY);
      chk("b8_beat", 32'(HGRANT), (i == 8) ? 32'h040 : 32'h008);
    end
    cyc(9'h000, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("park3", 32'(HGRANT), 32'h001);

    // Master 2 INCR held for MAX_INCR_BEATS accepted beats, master 4 waiting
    cyc(9'h014, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("incr_grant2", 32'(HGRANT), 32'h004);
    cyc(9'h014, T_NONSEQ, B_INCR, 1'b1, R_OKAY); chk("incr_beat1", 32'(HGRANT), 32'h004);
    for (int i = 0; i < 16; i++) begin
      cyc(9'h014, (i == 7) ? T_BUSY : T_SEQ, B_INCR, 1'b1, R_OKAY);
      chk("incr_beat", 32'(HGRANT), (i == 15) ? 32'h010 : 32'h004);
    end
    cyc(9'h000, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("park4", 32'(HGRANT), 32'h001);

    // Master 1 INCR16 retried on beat 5
    cyc(9'h0A2, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("rt_grant1", 32'(HGRANT), 32'h002);
    cyc(9'h0A2, T_NONSEQ, B_INCR16, 1'b1, R_OKAY);
    repeat (3) cyc(9'h0A2, T_SEQ, B_INCR16, 1'b1, R_OKAY);
    chk("rt_beat4", 32'(HGRANT), 32'h002);
    cyc(9'h0A2, T_SEQ, B_INCR16, 1'b0, R_RETRY); chk("rt_wait", 32'(HGRANT), 32'h002);
    cyc(9'h0A2, T_IDLE, B_INCR16, 1'b1, R_RETRY); chk("rt_next", 32'(HGRANT), 32'h020);
    cyc(9'h0A2, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rt_m7", 32'(HGRANT), 32'h080);
    cyc(9'h0A2, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY); chk("rt_m1_last", 32'(HGRANT), 32'h002);
    cyc(9'h000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);

    // HREADY low freezes everything while requests change
    repeat (2) cyc(9'h100, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);
    chk("wait_pre_grant", 32'(HGRANT), 32'h100);
    for (int i = 0; i < 5; i++) begin
      cyc(hold_req[i], T_NONSEQ, B_INCR8, 1'b0, R_OKAY);
      chk("wait_grant", 32'(HGRANT), 32'h100);
      chk("wait_hmaster", 32'(HMASTER), 32'd8);
    end

    // Asynchronous reset in the middle of an INCR4 burst
    cyc(9'h008, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("ar_grant3", 32'(HGRANT), 32'h008);
    cyc(9'h048, T_NONSEQ, B_INCR4, 1'b1, R_OKAY);
    cyc(9'h048, T_SEQ, B_INCR4, 1'b1, R_OKAY);
    chk("ar_hm3", 32'(HMASTER), 32'd3);
    #2 HRESETn = 1'b0;
    #1;
    chk("ar_grant", 32'(HGRANT), 32'h001);
    chk("ar_hmaster", 32'(HMASTER), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc(9'h040, T_IDLE, B_SINGLE, 1'b1, R_OKAY); chk("ar_after", 32'(HGRANT), 32'h040);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
